// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the stream/memory DMA blocks:
//   - dma_state_t     : controller state encodings (ST_IDLE, ST_RUN, ST_FIN)
//   - bytes_per_beat  : bytes carried by one DATA_W-bit beat
//   - clog2           : ceiling log2, used to size FIFO pointers
// No ports (package).
// -----------------------------------------------------------------------------
package dma_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } dma_state_t;

   function automatic int bytes_per_beat(input int data_w);
      return data_w / 8;
   endfunction

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if (int'(32'd1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// -----------------------------------------------------------------------------
// dma_sync_fifo
// Single-clock FIFO with full/empty flags. A push and a pop in the same cycle
// are both honoured and leave the occupancy unchanged. A push while full or a
// pop while empty is ignored. FIFO_DEPTH must be a power of two (>= 2) so the
// pointers wrap naturally.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en, wr_data    push request and data
//   rd_en, rd_data    pop request; rd_data shows the head entry
//   full, empty       occupancy flags
// -----------------------------------------------------------------------------
module dma_sync_fifo
   import dma_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty
);

   localparam int PTR_W = clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

   logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [PTR_W:0]    count_r;
   logic              wr_ok_s;
   logic              rd_ok_s;

   assign full    = (count_r == DEPTH_C);
   assign empty   = (count_r == {(PTR_W + 1){1'b0}});
   assign wr_ok_s = wr_en && !full;
   assign rd_ok_s = rd_en && !empty;
   assign rd_data = mem_r[rd_ptr_r];

   // Storage array, written on an accepted push
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= {DATA_W{1'b0}};
         end
      end else if (wr_ok_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointers and occupancy count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {(PTR_W + 1){1'b0}};
      end else begin
         if (wr_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (rd_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({wr_ok_s, rd_ok_s})
            2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
            2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/axis_dma_write_2d.sv
// -----------------------------------------------------------------------------
// axis_dma_write_2d
// Stream-to-memory write DMA. Accepts an AXI-Stream of DATA_W-bit beats and
// writes them as a 2D block: num_rows rows of row_len beats, each row starting
// row_stride bytes after the previous one. A small FIFO decouples the stream
// from the memory port, which has its own ready/valid backpressure.
//
// Optional feature macro: DMA_WR_TLAST_CHECK_EN
//   When defined, s_axis_tlast and err exist; each accepted beat's tlast is
//   compared against the expected end-of-row position and any mismatch sets
//   the sticky err flag (cleared by the next accepted start). The data path
//   always follows the programmed counts regardless of tlast.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start                           one-cycle request, honoured only when idle
//   base_addr, row_len, num_rows,   transfer configuration, latched on start
//   row_stride
//   busy, done                      transfer in progress / completion pulse
//   s_axis_tvalid/tdata/tready      input stream
//   s_axis_tlast, err               framing check (macro only)
//   mem_wr_valid/ready/addr/data    memory write port
// -----------------------------------------------------------------------------
module axis_dma_write_2d
   import dma_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int CNT_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  row_len,
   input  logic [CNT_W-1:0]  num_rows,
   input  logic [ADDR_W-1:0] row_stride,
   output logic              busy,
   output logic              done,
   input  logic              s_axis_tvalid,
   input  logic [DATA_W-1:0] s_axis_tdata,
   output logic              s_axis_tready,
`ifdef DMA_WR_TLAST_CHECK_EN
   input  logic              s_axis_tlast,
   output logic              err,
`endif
   output logic              mem_wr_valid,
   input  logic              mem_wr_ready,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [DATA_W-1:0] mem_wr_data
);

   localparam int BPB   = bytes_per_beat(DATA_W);
   localparam int TOT_W = 2 * CNT_W;

   dma_state_t        state_r;
   dma_state_t        state_n_s;

   logic [CNT_W-1:0]  row_len_r;
   logic [CNT_W-1:0]  num_rows_r;
   logic [ADDR_W-1:0] stride_r;
   logic [ADDR_W-1:0] row_base_r;
   logic [CNT_W-1:0]  col_r;
   logic [CNT_W-1:0]  row_r;
   logic [TOT_W-1:0]  total_r;
   logic [TOT_W-1:0]  beats_in_r;

   logic              start_ok_s;
   logic              zero_len_s;
   logic              in_fire_s;
   logic              out_fire_s;
   logic              last_col_s;
   logic              last_row_s;
   logic              final_wr_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic [DATA_W-1:0] fifo_rd_data_s;
   logic [ADDR_W-1:0] addr_s;

   assign start_ok_s = start && (state_r == ST_IDLE);
   assign zero_len_s = (row_len == {CNT_W{1'b0}}) || (num_rows == {CNT_W{1'b0}});

   // Total is held at double width so row_len*num_rows never overflows.
   assign s_axis_tready = (state_r == ST_RUN) && !fifo_full_s && (beats_in_r < total_r);
   assign mem_wr_valid  = (state_r == ST_RUN) && !fifo_empty_s;
   assign busy          = (state_r == ST_RUN);
   assign done          = (state_r == ST_FIN);

   assign in_fire_s  = s_axis_tvalid && s_axis_tready;
   assign out_fire_s = mem_wr_valid && mem_wr_ready;
   assign last_col_s = (col_r == row_len_r - CNT_W'(1));
   assign last_row_s = (row_r == num_rows_r - CNT_W'(1));
   assign final_wr_s = out_fire_s && last_col_s && last_row_s;

   assign addr_s = row_base_r + ADDR_W'(col_r) * ADDR_W'(BPB);

   // Address and data are forced to zero whenever no request is presented,
   // which also gives the all-zero outputs required out of reset.
   assign mem_wr_addr = mem_wr_valid ? addr_s : {ADDR_W{1'b0}};
   assign mem_wr_data = mem_wr_valid ? fifo_rd_data_s : {DATA_W{1'b0}};

   dma_sync_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (in_fire_s),
      .wr_data (s_axis_tdata),
      .rd_en   (out_fire_s),
      .rd_data (fifo_rd_data_s),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s)
   );

   // Controller state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_n_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_n_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_n_s = zero_len_s ? ST_FIN : ST_RUN;
            end else begin
               state_n_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (final_wr_s) begin
               state_n_s = ST_FIN;
            end else begin
               state_n_s = ST_RUN;
            end
         end
         ST_FIN:  state_n_s = ST_IDLE;
         default: state_n_s = ST_IDLE;
      endcase
   end

   // Configuration latch plus input/output position counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_len_r  <= {CNT_W{1'b0}};
         num_rows_r <= {CNT_W{1'b0}};
         stride_r   <= {ADDR_W{1'b0}};
         row_base_r <= {ADDR_W{1'b0}};
         col_r      <= {CNT_W{1'b0}};
         row_r      <= {CNT_W{1'b0}};
         total_r    <= {TOT_W{1'b0}};
         beats_in_r <= {TOT_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  row_len_r  <= row_len;
                  num_rows_r <= num_rows;
                  stride_r   <= row_stride;
                  row_base_r <= base_addr;
                  col_r      <= {CNT_W{1'b0}};
                  row_r      <= {CNT_W{1'b0}};
                  total_r    <= TOT_W'(row_len) * TOT_W'(num_rows);
                  beats_in_r <= {TOT_W{1'b0}};
               end
            end
            ST_RUN: begin
               if (in_fire_s) begin
                  beats_in_r <= beats_in_r + TOT_W'(1);
               end
               if (out_fire_s) begin
                  if (last_col_s) begin
                     col_r      <= {CNT_W{1'b0}};
                     row_r      <= row_r + CNT_W'(1);
                     row_base_r <= row_base_r + stride_r;
                  end else begin
                     col_r <= col_r + CNT_W'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef DMA_WR_TLAST_CHECK_EN
   logic [CNT_W-1:0] in_col_r;
   logic             err_r;
   logic             exp_last_s;

   assign exp_last_s = (in_col_r == row_len_r - CNT_W'(1));
   assign err        = err_r;

   // Input-side column tracker and sticky framing error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_col_r <= {CNT_W{1'b0}};
         err_r    <= 1'b0;
      end else if (start_ok_s) begin
         in_col_r <= {CNT_W{1'b0}};
         err_r    <= 1'b0;
      end else if (in_fire_s) begin
         if (s_axis_tlast != exp_last_s) begin
            err_r <= 1'b1;
         end
         if (exp_last_s) begin
            in_col_r <= {CNT_W{1'b0}};
         end else begin
            in_col_r <= in_col_r + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_axis_dma_write_2d.sv
// -----------------------------------------------------------------------------
// tb_axis_dma_write_2d
// Directed + randomized bench for axis_dma_write_2d. The expected write
// sequence (address list from base/stride/row geometry, data in stream order)
// is built up front; a negedge monitor compares every memory handshake and the
// handshake signals against a transaction-level model of the transfer.
// -----------------------------------------------------------------------------
module tb_axis_dma_write_2d;

   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 32;
   localparam int CNT_W      = 16;
   localparam int FIFO_DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [CNT_W-1:0]  row_len;
   logic [CNT_W-1:0]  num_rows;
   logic [ADDR_W-1:0] row_stride;
   logic              busy;
   logic              done;
   logic              s_axis_tvalid;
   logic [DATA_W-1:0] s_axis_tdata;
   logic              s_axis_tready;
`ifdef DMA_WR_TLAST_CHECK_EN
   logic              s_axis_tlast;
   logic              err;
`endif
   logic              mem_wr_valid;
   logic              mem_wr_ready;
   logic [ADDR_W-1:0] mem_wr_addr;
   logic [DATA_W-1:0] mem_wr_data;

   axis_dma_write_2d #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .row_len(row_len), .num_rows(num_rows), .row_stride(row_stride),
      .busy(busy), .done(done),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
      .s_axis_tready(s_axis_tready),
`ifdef DMA_WR_TLAST_CHECK_EN
      .s_axis_tlast(s_axis_tlast), .err(err),
`endif
      .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
      .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Model state shared by the stimulus and the monitor
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];
   int          in_cnt, wr_cnt, done_cnt, cur_total;
   int          first_wr_cyc, last_wr_cyc, occ_m;
   int          cyc_cnt = 0;
   int          rdy_mode = 0;
   bit          mon_en, xfer_active, done_due, saw_full, prev_stall;
   logic [31:0] prev_addr, prev_data;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Memory-side ready pattern generator
   initial begin
      int phase;
      phase = 0;
      mem_wr_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: mem_wr_ready = 1'b1;
            1: begin
               mem_wr_ready = (phase == 0);
               phase = (phase + 1) % 4;
            end
            default: mem_wr_ready = ($urandom_range(0, 1) == 1);
         endcase
      end
   end

   // Transaction-level monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (!mon_en) begin
         prev_stall = 1'b0;
      end else begin
         occ_m = in_cnt - wr_cnt;
         if (occ_m == FIFO_DEPTH) saw_full = 1'b1;
         check("busy", busy, xfer_active);
         check("done", done, done_due);
         if (done) done_cnt++;
         done_due = 1'b0;
         check("s_axis_tready", s_axis_tready,
               xfer_active && (occ_m < FIFO_DEPTH) && (in_cnt < cur_total));
         check("mem_wr_valid", mem_wr_valid, xfer_active && (occ_m > 0));
         if (prev_stall) begin
            check("addr_stable", mem_wr_addr, prev_addr);
            check("data_stable", mem_wr_data, prev_data);
         end
         if (s_axis_tvalid && s_axis_tready) in_cnt++;
         if (mem_wr_valid && mem_wr_ready) begin
            check("write_pending", exp_addr_q.size() > 0, 1'b1);
            if (exp_addr_q.size() > 0) begin
               check("mem_wr_addr", mem_wr_addr, exp_addr_q.pop_front());
               check("mem_wr_data", mem_wr_data, exp_data_q.pop_front());
            end
            if (first_wr_cyc < 0) first_wr_cyc = cyc_cnt;
            last_wr_cyc = cyc_cnt;
            wr_cnt++;
            if (wr_cnt == cur_total) begin
               xfer_active = 1'b0;
               done_due    = 1'b1;
            end
         end
         prev_stall = mem_wr_valid && !mem_wr_ready;
         prev_addr  = mem_wr_addr;
         prev_data  = mem_wr_data;
      end
   end

   // One complete transfer: build the expected write list, start, stream, await done
   task automatic do_xfer(input logic [31:0] base, input logic [15:0] rl,
                          input logic [15:0] nr, input logic [31:0] stride,
                          input bit tv_rand, input bit restart, input int abort_n,
                          input int tlast_bad);
      logic [31:0] beats[$];
      logic [31:0] a;
      int total, i, n;
      bit hs;
      total = int'(rl) * int'(nr);
      exp_addr_q.delete();
      exp_data_q.delete();
      for (int r = 0; r < int'(nr); r++) begin
         for (int c = 0; c < int'(rl); c++) begin
            a = base + stride * 32'(r) + 32'(c) * 32'd4;
            exp_addr_q.push_back(a);
         end
      end
      for (int k = 0; k < total; k++) begin
         beats.push_back($urandom);
         exp_data_q.push_back(beats[k]);
      end
      in_cnt = 0; wr_cnt = 0; done_cnt = 0; cur_total = total;
      first_wr_cyc = -1; last_wr_cyc = -1; saw_full = 1'b0; done_due = 1'b0;

      @(posedge clk); #1;
      start = 1'b1; base_addr = base; row_len = rl; num_rows = nr; row_stride = stride;
      @(posedge clk); #1;
      start = 1'b0;
      if (total > 0) xfer_active = 1'b1;
      else           done_due    = 1'b1;
      // Configuration inputs changing after acceptance must not matter
      base_addr = $urandom; row_len = 16'($urandom); num_rows = 16'($urandom);
      row_stride = $urandom;

      i = 0; n = 0;
      while (i < total && n < 3000 && !(abort_n > 0 && wr_cnt >= abort_n)) begin
         s_axis_tvalid = tv_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
         s_axis_tdata  = beats[i];
`ifdef DMA_WR_TLAST_CHECK_EN
         s_axis_tlast  = ((i % int'(rl)) == int'(rl) - 1) ^ (i == tlast_bad);
`endif
         start = restart && (n == 2);
         @(negedge clk);
         hs = s_axis_tvalid && s_axis_tready;
         @(posedge clk); #1;
         if (hs) i++;
         n++;
      end
      s_axis_tvalid = 1'b0;
      start = 1'b0;

      if (abort_n == 0) begin
         check("beats_accepted", i, total);
         n = 0;
         while (done_cnt == 0 && n < 1000) begin
            @(posedge clk); #1;
            n++;
         end
         repeat (3) @(posedge clk);
         #1;
         check("done_pulses", done_cnt, 1);
         check("write_count", wr_cnt, total);
         check("writes_left", exp_addr_q.size(), 0);
         check("busy_after", busy, 1'b0);
`ifdef DMA_WR_TLAST_CHECK_EN
         check("err", err, tlast_bad >= 0);
`endif
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; base_addr = '0; row_len = '0; num_rows = '0;
      row_stride = '0; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
`ifdef DMA_WR_TLAST_CHECK_EN
      s_axis_tlast = 1'b0;
`endif
      mon_en = 1'b0; xfer_active = 1'b0; done_due = 1'b0; cur_total = 0;
      in_cnt = 0; wr_cnt = 0; done_cnt = 0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_tready", s_axis_tready, 1'b0);
      check("rst_valid", mem_wr_valid, 1'b0);
      check("rst_addr", mem_wr_addr, 32'h0);
      check("rst_data", mem_wr_data, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      mon_en = 1'b1;

      // Linear row, everything streaming at full rate
      rdy_mode = 0;
      do_xfer(32'h1000, 16'd8, 16'd1, 32'h0, 1'b0, 1'b0, 0, -1);
      check("linear_back_to_back", last_wr_cyc - first_wr_cyc, 7);

      // 3x3 block with row stride
      do_xfer(32'h2000, 16'd3, 16'd3, 32'h100, 1'b0, 1'b0, 0, -1);
      check("2d_back_to_back", last_wr_cyc - first_wr_cyc, 8);

      // Memory backpressure: 1 cycle ready, 3 cycles stalled
      rdy_mode = 1;
      do_xfer(32'h5000, 16'd16, 16'd1, 32'h0, 1'b0, 1'b0, 0, -1);
      check("fifo_filled", saw_full, 1'b1);
      rdy_mode = 0;

      // Zero-length transfers
      do_xfer(32'h7000, 16'd0, 16'd5, 32'h40, 1'b0, 1'b0, 0, -1);
      do_xfer(32'h6000, 16'd5, 16'd0, 32'h40, 1'b0, 1'b0, 0, -1);

      // Second start while busy is ignored
      do_xfer(32'h8000, 16'd4, 16'd1, 32'h0, 1'b0, 1'b1, 0, -1);

      // Asynchronous reset after three writes
      do_xfer(32'h1000, 16'd8, 16'd1, 32'h0, 1'b0, 1'b0, 3, -1);
      mon_en = 1'b0; xfer_active = 1'b0; done_due = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", done, 1'b0);
      check("midrst_tready", s_axis_tready, 1'b0);
      check("midrst_valid", mem_wr_valid, 1'b0);
      check("midrst_addr", mem_wr_addr, 32'h0);
      check("midrst_data", mem_wr_data, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      mon_en = 1'b1;
      do_xfer(32'h3000, 16'd2, 16'd1, 32'h0, 1'b0, 1'b0, 0, -1);

`ifdef DMA_WR_TLAST_CHECK_EN
      // Bad framing on beat 2 flags err; the next transfer clears it
      do_xfer(32'h4000, 16'd4, 16'd1, 32'h0, 1'b0, 1'b0, 0, 2);
      do_xfer(32'h4100, 16'd4, 16'd1, 32'h0, 1'b0, 1'b0, 0, -1);
`endif

      // Randomized geometry, stream gaps and memory stalls, incl. address wrap
      rdy_mode = 2;
      for (int t = 0; t < 6; t++) begin
         logic [31:0] rb;
         rb = (t == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
         do_xfer(rb, 16'($urandom_range(1, 6)), 16'($urandom_range(1, 4)),
                 $urandom, 1'b1, 1'b0, 0, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
